// File: rtl/aes_pkg.sv
// Shared AES tables, GF(2^8) helpers, key-schedule steps and decoder FSM state type.
package aes_pkg;

    localparam int NR = 10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_KEYEXP,
        S_ADDKEY,
        S_ROUND,
        S_FINAL,
        S_HOLD
    } dec_state_e;

    // Byte b of each table lives at bits [2047-8*b -: 8].
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[2047 - 8*int'(b) -: 8];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[2047 - 8*int'(b) -: 8];
    endfunction

    function automatic logic [7:0] gf_mul2(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul9(input logic [7:0] b);
        return gf_mul2(gf_mul2(gf_mul2(b))) ^ b;
    endfunction

    function automatic logic [7:0] gf_mul11(input logic [7:0] b);
        return gf_mul2(gf_mul2(gf_mul2(b))) ^ gf_mul2(b) ^ b;
    endfunction

    function automatic logic [7:0] gf_mul13(input logic [7:0] b);
        return gf_mul2(gf_mul2(gf_mul2(b))) ^ gf_mul2(gf_mul2(b)) ^ b;
    endfunction

    function automatic logic [7:0] gf_mul14(input logic [7:0] b);
        return gf_mul2(gf_mul2(gf_mul2(b))) ^ gf_mul2(gf_mul2(b)) ^ gf_mul2(b);
    endfunction

    function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
        return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w0 = k[127:96] ^ sub_rot_word(k[31:0]) ^ {rc, 24'h0};
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0]  ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] key_inv(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w3 = k[31:0]  ^ k[63:32];
        w2 = k[63:32] ^ k[95:64];
        w1 = k[95:64] ^ k[127:96];
        w0 = k[127:96] ^ sub_rot_word(w3) ^ {rc, 24'h0};
        return {w0, w1, w2, w3};
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns unless last.
// Purely combinational; no latency, no backpressure.
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] st_in,
    input  logic [127:0] rk,
    input  logic         last,
    output logic [127:0] st_out
);

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {gf_mul14(a0) ^ gf_mul11(a1) ^ gf_mul13(a2) ^ gf_mul9(a3),
                gf_mul9(a0)  ^ gf_mul14(a1) ^ gf_mul11(a2) ^ gf_mul13(a3),
                gf_mul13(a0) ^ gf_mul9(a1)  ^ gf_mul14(a2) ^ gf_mul11(a3),
                gf_mul11(a0) ^ gf_mul13(a1) ^ gf_mul9(a2)  ^ gf_mul14(a3)};
    endfunction

    logic [127:0] ark;
    logic [127:0] mix;

    // Byte index is 4*col+row; row r of the output column c comes from input column c-r.
    always_comb begin
        ark = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                ark[127 - 8*(4*c + r) -: 8] =
                    inv_sbox(st_in[127 - 8*(4*((c + 4 - r) % 4) + r) -: 8]) ^
                    rk[127 - 8*(4*c + r) -: 8];
            end
        end
    end

    always_comb begin
        mix = '0;
        for (int c = 0; c < 4; c++) begin
            mix[127 - 32*c -: 32] = inv_mix_col(ark[127 - 32*c -: 32]);
        end
    end

    assign st_out = last ? ark : mix;

endmodule

// File: rtl/aes_128_dec_iter.sv
// Iterative AES-128 decryptor, one block in flight; on-the-fly key expansion then reverse schedule.
// Latency 21 edges accept-to-out_valid (11 on a key-cache hit when AES_DEC_KEY_CACHE_EN is defined).
// in_ready only in IDLE; result held in HOLD until out_ready is sampled high.
module aes_128_dec_iter #(
    parameter int NR = 10,
    parameter int KW = 128
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [KW-1:0] in_state,
    input  logic [KW-1:0] in_key,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [KW-1:0] out_data,
    output logic          busy
);
    import aes_pkg::*;

    if (NR != aes_pkg::NR || KW != 128) begin : g_param_check
        $error("aes_128_dec_iter: only NR=10 and KW=128 are legal");
    end

    dec_state_e   state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [127:0] st_q, st_d;
    logic [127:0] rk_q, rk_d;
    logic         out_vld_q, out_vld_d;
    logic [127:0] out_dat_q, out_dat_d;
    logic [127:0] rk_fwd;
    logic [127:0] rnd_out;
    logic         accept;
    logic         cache_hit;
    logic [127:0] cache_rk;

    assign accept = in_valid && (state_q == S_IDLE);
    assign rk_fwd = key_fwd(rk_q, (cnt_q >= 4'd1 && cnt_q <= 4'd10) ? RCON[cnt_q] : 8'h00);

    aes_inv_round u_round (
        .st_in  (st_q),
        .rk     (rk_q),
        .last   (state_q == S_FINAL),
        .st_out (rnd_out)
    );

`ifdef AES_DEC_KEY_CACHE_EN
    logic         cache_vld_q;
    logic [127:0] cache_key_q, cache_rk_q, key_q;

    assign cache_hit = cache_vld_q && (in_key == cache_key_q);
    assign cache_rk  = cache_rk_q;

    // The cache captures the key/rk10 pair only once a full expansion completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cache_vld_q <= 1'b0;
            cache_key_q <= '0;
            cache_rk_q  <= '0;
            key_q       <= '0;
        end else begin
            if (accept) begin
                key_q <= in_key;
            end
            if (state_q == S_KEYEXP && cnt_q == 4'd10) begin
                cache_vld_q <= 1'b1;
                cache_key_q <= key_q;
                cache_rk_q  <= rk_fwd;
            end
        end
    end
`else
    assign cache_hit = 1'b0;
    assign cache_rk  = '0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        st_d      = st_q;
        rk_d      = rk_q;
        out_vld_d = out_vld_q;
        out_dat_d = out_dat_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    st_d  = in_state;
                    cnt_d = 4'd1;
                    if (cache_hit) begin
                        rk_d    = cache_rk;
                        state_d = S_ADDKEY;
                    end else begin
                        rk_d    = in_key;
                        state_d = S_KEYEXP;
                    end
                end
            end
            S_KEYEXP: begin
                rk_d = rk_fwd;
                if (cnt_q == 4'd10) begin
                    state_d = S_ADDKEY;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_ADDKEY: begin
                st_d    = st_q ^ rk_q;
                rk_d    = key_inv(rk_q, RCON[10]);
                cnt_d   = 4'd9;
                state_d = S_ROUND;
            end
            S_ROUND: begin
                st_d  = rnd_out;
                rk_d  = key_inv(rk_q, (cnt_q >= 4'd1 && cnt_q <= 4'd10) ? RCON[cnt_q] : 8'h00);
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_FINAL;
                end
            end
            S_FINAL: begin
                out_dat_d = rnd_out;
                out_vld_d = 1'b1;
                state_d   = S_HOLD;
            end
            S_HOLD: begin
                if (out_ready) begin
                    out_vld_d = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            st_q      <= '0;
            rk_q      <= '0;
            out_vld_q <= 1'b0;
            out_dat_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            st_q      <= st_d;
            rk_q      <= rk_d;
            out_vld_q <= out_vld_d;
            out_dat_q <= out_dat_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = out_vld_q;
    assign out_data  = out_dat_q;

endmodule
